// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: memory fetch bus, redirect and decode handoff signals
interface instruction_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        exception_inst_misaligned;
  logic [31:0] fault_addr;
  modport master (
    output im_req, im_addr, if_valid, if_inst, if_pc, exception_inst_misaligned, fault_addr,
    input  im_ack, im_rvalid, im_rdata, redirect, redirect_pc, id_ready
  );
  modport slave (
    input  im_req, im_addr, if_valid, if_inst, if_pc, exception_inst_misaligned, fault_addr,
    output im_ack, im_rvalid, im_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential fetch with credit-limited buffering and redirect flush
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic clk,
  input logic resetb,
  instruction_fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, fault_q, fault_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [CW:0]   credit;
  logic [31:0]   target;
  logic          ack, drop_rsp, push, pop, misaligned;
  always_comb begin
    credit     = {1'b0, outst_q} + {1'b0, count_q};
    target     = {bus.redirect_pc[31:2], 2'b00};
    misaligned = |bus.redirect_pc[1:0];
    // Credits cover both buffered and in-flight words, so a returning word always has a slot
    bus.im_req = resetb && !bus.redirect && state_q == FETCH && credit < (CW+1)'(FIFO_DEPTH);
    ack        = bus.im_req && bus.im_ack;
    drop_rsp   = bus.im_rvalid && drop_q != '0;
    push       = bus.im_rvalid && drop_q == '0 && !bus.redirect;
    pop        = bus.if_valid && bus.id_ready && !bus.redirect;
    outst_d    = outst_q + CW'(ack) - CW'(bus.im_rvalid);
    drop_d     = bus.redirect ? outst_d : drop_q - CW'(drop_rsp);
    count_d    = bus.redirect ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d       = bus.redirect ? '0 : wr_q + AW'(push);
    rd_d       = bus.redirect ? '0 : rd_q + AW'(pop);
    fetch_pc_d = bus.redirect ? target : fetch_pc_q + (ack ? 32'd4 : 32'd0);
    resp_pc_d  = bus.redirect ? target : resp_pc_q + (push ? 32'd4 : 32'd0);
    state_d    = bus.redirect ? (misaligned ? HALTED : FETCH) : state_q;
    fault_d    = bus.redirect && misaligned ? bus.redirect_pc : fault_q;
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      fault_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      fault_q    <= fault_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]   <= resp_pc_q;
      inst_mem_q[wr_q] <= bus.im_rdata;
    end
    if (resetb) assert (!(push && !pop && count_q == CW'(FIFO_DEPTH)));
  end
  assign bus.if_valid                  = count_q != '0;
  assign bus.if_inst                   = bus.if_valid ? inst_mem_q[rd_q] : 32'h0000_0013;
  assign bus.if_pc                     = bus.if_valid ? pc_mem_q[rd_q] : resp_pc_q;
  assign bus.im_addr                   = fetch_pc_q;
  assign bus.exception_inst_misaligned = state_q == HALTED;
  assign bus.fault_addr                = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random memory/decoder traffic checked against a queue-based stream model
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic resetb;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (.clk(clk), .resetb(resetb), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  req_t mq[$];
  ent_t fq[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] m_fetch = 32'h0, m_stream = 32'h0, m_fault = 32'h0;
  bit m_halt = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic cycle(input bit r, input logic [31:0] rpc, input bit rdy, input bit ak, input int lat);
    bit rv, exp_req;
    req_t q;
    bus.redirect = r;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
    bus.im_ack = ak;
    rv = mq.size() > 0 && mq[0].due <= cyc;
    bus.im_rvalid = rv;
    bus.im_rdata = rv ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_req = !r && !m_halt && (mq.size() + fq.size()) < 4;
    check("im_req", {31'b0, bus.im_req}, {31'b0, exp_req});
    if (exp_req) check("im_addr", bus.im_addr, m_fetch);
    check("if_valid", {31'b0, bus.if_valid}, {31'b0, fq.size() > 0});
    if (fq.size() > 0) begin
      check("if_pc", bus.if_pc, fq[0].pc);
      check("if_inst", bus.if_inst, fq[0].inst);
    end else check("if_inst_nop", bus.if_inst, 32'h0000_0013);
    check("misaligned", {31'b0, bus.exception_inst_misaligned}, {31'b0, m_halt});
    check("fault_addr", bus.fault_addr, m_fault);
    if (fq.size() > 0 && rdy && !r) void'(fq.pop_front());
    if (rv) begin
      q = mq.pop_front();
      if (!q.stale && !r) begin
        fq.push_back('{m_stream, mem_word(m_stream)});
        m_stream += 4;
      end
    end
    if (exp_req && ak) begin
      mq.push_back('{bus.im_addr, cyc + lat, 1'b0});
      m_fetch += 4;
    end
    if (r) begin
      fq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_fetch = {rpc[31:2], 2'b00};
      m_stream = m_fetch;
      m_halt = |rpc[1:0];
      if (m_halt) m_fault = rpc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  initial begin
    resetb = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    bus.im_ack = 1'b0;
    bus.im_rvalid = 1'b0;
    bus.im_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_im_req", {31'b0, bus.im_req}, 32'h0);
    check("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    check("rst_if_inst", bus.if_inst, 32'h0000_0013);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_misaligned", {31'b0, bus.exception_inst_misaligned}, 32'h0);
    check("rst_fault_addr", bus.fault_addr, 32'h0);
    resetb = 1'b1;
    // streaming at one word per cycle with a 1-cycle memory
    repeat (20) cycle(0, 0, 1, 1, 1);
    // decoder stalled: requests stop once four words are owed
    repeat (10) cycle(0, 0, 0, 1, 1);
    check("stall_full", {31'b0, bus.if_valid}, 32'h1);
    repeat (15) cycle(0, 0, 1, 1, 1);
    // 3-cycle memory, redirect with responses in flight
    for (int i = 0; i < 20 && mq.size() < 2; i++) cycle(0, 0, 1, 1, 3);
    check("inflight_before_redirect", (mq.size() >= 2) ? 32'h1 : 32'h0, 32'h1);
    cycle(1, 32'h100, 1, 1, 3);
    for (int i = 0; i < 20 && fq.size() == 0; i++) cycle(0, 0, 1, 1, 3);
    check("first_pc_after_redirect", bus.if_pc, 32'h100);
    repeat (10) cycle(0, 0, 1, 1, 3);
    // redirect coinciding with a returning word and a pop
    repeat (6) cycle(0, 0, 1, 1, 1);
    for (int i = 0; i < 10 && !(mq.size() > 0 && mq[0].due <= cyc && fq.size() > 0); i++) cycle(0, 0, 1, 1, 1);
    cycle(1, 32'h400, 1, 1, 1);
    repeat (8) cycle(0, 0, 1, 1, 1);
    check("drop_cnt_zero", {28'b0, 4'(dut.drop_q)}, 32'h0);
    // misaligned target halts fetch until an aligned redirect
    cycle(1, 32'h102, 1, 1, 1);
    check("misaligned_flag", {31'b0, bus.exception_inst_misaligned}, 32'h1);
    check("misaligned_fault", bus.fault_addr, 32'h102);
    repeat (5) cycle(0, 0, 1, 1, 1);
    cycle(1, 32'h200, 1, 1, 1);
    repeat (10) cycle(0, 0, 1, 1, 1);
    // address wrap past the top of memory
    cycle(1, 32'hFFFF_FFF4, 1, 1, 1);
    repeat (12) cycle(0, 0, 1, 1, 1);
    // randomized traffic with occasional (sometimes misaligned) redirects
    for (int i = 0; i < 400; i++) begin
      bit r;
      logic [31:0] rpc;
      r = ($urandom % 20) == 0;
      rpc = {20'b0, 10'($urandom), 2'b00} | ((($urandom % 6) == 0) ? 32'h1 : 32'h0);
      cycle(r, rpc, ($urandom % 4) != 0, ($urandom % 3) != 0, $urandom_range(1, 3));
    end
    for (int i = 0; i < 30 && mq.size() > 0; i++) cycle(0, 0, 1, 0, 1);
    check("drain_done", mq.size(), 32'h0);
    check("drop_cnt_drained", {28'b0, 4'(dut.drop_q)}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
